// File: rtl/spectrum_pkg.sv
// rtl/spectrum_pkg.sv - shared constants, colours and state type for the spectrum column writer
// Purpose: default geometry, pixel bus widths, default colours, colour-band
// boundary and the writer state enum. No ports.
package spectrum_pkg;

  localparam int NUM_COLS_DEF = 96;
  localparam int NUM_ROWS_DEF = 64;
  localparam int PIX_ADDR_W   = 13;
  localparam int PIX_DATA_W   = 8;

  localparam logic [PIX_DATA_W-1:0] BG_COLOR_DEF     = 8'h00;
  localparam logic [PIX_DATA_W-1:0] BAR_COLOR_DEF    = 8'h1C;
  localparam logic [PIX_DATA_W-1:0] BAR_HI_COLOR_DEF = 8'hE0;
  localparam logic [PIX_DATA_W-1:0] PEAK_COLOR_DEF   = 8'hFF;

  // Rows above this index use the high bar colour.
  localparam int HI_BAND_ROWS = 16;

  typedef enum logic {IDLE, DRAW} state_t;

endpackage

// File: rtl/spectrum_col_writer_if.sv
// rtl/spectrum_col_writer_if.sv - bin stream and frame-buffer port A bundle
// Purpose: groups the magnitude stream, the frame-buffer write port and the
// status outputs of spectrum_col_writer.
// Signals: bin_valid/bin_ready/bin_mag/bin_last (magnitude stream),
// pix_ada/pix_dina/pix_wrea/pix_cea (buffer write port A), frame_done, busy.
// Modports: slave = the column writer, master = the bin source / observer.
interface spectrum_col_writer_if;

  logic                                bin_valid;
  logic                                bin_ready;
  logic [7:0]                          bin_mag;
  logic                                bin_last;
  logic [spectrum_pkg::PIX_ADDR_W-1:0] pix_ada;
  logic [spectrum_pkg::PIX_DATA_W-1:0] pix_dina;
  logic                                pix_wrea;
  logic                                pix_cea;
  logic                                frame_done;
  logic                                busy;

  modport slave (
    input  bin_valid, bin_mag, bin_last,
    output bin_ready, pix_ada, pix_dina, pix_wrea, pix_cea, frame_done, busy
  );

  modport master (
    output bin_valid, bin_mag, bin_last,
    input  bin_ready, pix_ada, pix_dina, pix_wrea, pix_cea, frame_done, busy
  );

endinterface

// File: rtl/spectrum_peak_store.sv
// rtl/spectrum_peak_store.sv - per-column peak-hold registers with frame-based decay
// Purpose: keeps one 6-bit peak per column, offers max(peak[col], h) for the
// column being accepted, and decrements every peak once per DECAY_FRAMES frames.
// Ports: clk, reset (async, active high), col (column of the accepted bin),
// h (accepted bar height), update (store peak_new into peak[col]),
// frame_end (a bin_last column finished or was discarded), peak_new (out).
module spectrum_peak_store #(
  parameter int NUM_COLS     = 96,
  parameter int DECAY_FRAMES = 4,
  parameter int COL_W        = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [COL_W-1:0] col,
  input  logic [5:0]       h,
  input  logic             update,
  input  logic             frame_end,
  output logic [5:0]       peak_new
);

  logic [5:0]  peaks [NUM_COLS];
  logic [15:0] frame_cnt;
  logic        decay;

  // col may sit at NUM_COLS (saturated); such bins never update a peak.
  always_comb begin
    peak_new = h;
    if (col < COL_W'(NUM_COLS) && peaks[col] > h) peak_new = peaks[col];
  end

  assign decay = frame_end && (frame_cnt == 16'(DECAY_FRAMES - 1));

  // frame_end only happens in the last DRAW cycle or on a discard, so it
  // never coincides with a peak update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      for (int i = 0; i < NUM_COLS; i++) peaks[i] <= '0;
    end else begin
      if (frame_end) frame_cnt <= decay ? 16'd0 : frame_cnt + 16'd1;
      for (int i = 0; i < NUM_COLS; i++) begin
        if (decay && peaks[i] != 6'd0) peaks[i] <= peaks[i] - 6'd1;
      end
      if (update) peaks[col] <= peak_new;
    end
  end

endmodule

// File: rtl/spectrum_col_writer.sv
// rtl/spectrum_col_writer.sv - draws one spectrum bar column per accepted bin magnitude
// Purpose: each accepted bin becomes a 64-pixel column in the 96x64 frame
// buffer (row 0 at top), one pixel per cycle on write port A.
// Ports: clk, reset (async, active high), bus (spectrum_col_writer_if.slave:
// bin stream in, pix_* write port out, frame_done pulse, busy).
// Build option: SPECTRUM_PEAK_HOLD_EN adds per-column peak-hold markers.
module spectrum_col_writer
  import spectrum_pkg::*;
#(
  parameter int                    NUM_COLS     = NUM_COLS_DEF,
  parameter int                    NUM_ROWS     = NUM_ROWS_DEF,
  parameter logic [PIX_DATA_W-1:0] BG_COLOR     = BG_COLOR_DEF,
  parameter logic [PIX_DATA_W-1:0] BAR_COLOR    = BAR_COLOR_DEF,
  parameter logic [PIX_DATA_W-1:0] BAR_HI_COLOR = BAR_HI_COLOR_DEF,
  parameter logic [PIX_DATA_W-1:0] PEAK_COLOR   = PEAK_COLOR_DEF,
  parameter int                    DECAY_FRAMES = 4
) (
  input logic                 clk,
  input logic                 reset,
  spectrum_col_writer_if.slave bus
);

  localparam int COL_W = $clog2(NUM_COLS + 1);

  if (DECAY_FRAMES < 1) begin : g_decay_check
    $error("DECAY_FRAMES must be at least 1");
  end

  state_t                  state, state_nxt;
  logic [5:0]              row, row_nxt, h, h_nxt, pk, pk_nxt;
  logic [COL_W-1:0]        col, col_nxt;
  logic                    last_q, last_nxt;
  logic [PIX_ADDR_W-1:0]   ada, ada_nxt;
  logic [PIX_DATA_W-1:0]   dina, dina_nxt;
  logic                    wrea, wrea_nxt, fd, fd_nxt;
  logic                    accept, can_draw;
  logic [5:0]              bin_h, peak_new;

  // Peak marker wins over the bar; bar covers rows r with r + h >= 64.
  function automatic logic [PIX_DATA_W-1:0] pix_color(input logic [5:0] r,
                                                      input logic [5:0] hh,
                                                      input logic [5:0] p);
    if (p != 6'd0 && {1'b0, r} == 7'd64 - {1'b0, p}) return PEAK_COLOR;
    if ({1'b0, r} + {1'b0, hh} >= 7'd64)
      return (r < 6'(HI_BAND_ROWS)) ? BAR_HI_COLOR : BAR_COLOR;
    return BG_COLOR;
  endfunction

  assign bin_h    = bus.bin_mag[7:2];
  assign accept   = bus.bin_valid && bus.bin_ready;
  assign can_draw = col < COL_W'(NUM_COLS);

`ifdef SPECTRUM_PEAK_HOLD_EN
  spectrum_peak_store #(
    .NUM_COLS(NUM_COLS), .DECAY_FRAMES(DECAY_FRAMES), .COL_W(COL_W)
  ) u_peak (
    .clk(clk), .reset(reset), .col(col), .h(bin_h),
    .update(accept && can_draw), .frame_end(fd_nxt), .peak_new(peak_new)
  );
`else
  assign peak_new = 6'd0;
`endif

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    h_nxt     = h;
    pk_nxt    = pk;
    col_nxt   = col;
    last_nxt  = last_q;
    ada_nxt   = '0;
    dina_nxt  = '0;
    wrea_nxt  = 1'b0;
    fd_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          last_nxt = bus.bin_last;
          h_nxt    = bin_h;
          pk_nxt   = peak_new;
          row_nxt  = 6'd0;
          if (can_draw) begin
            state_nxt = DRAW;
            ada_nxt   = PIX_ADDR_W'(col);
            dina_nxt  = pix_color(6'd0, bin_h, peak_new);
            wrea_nxt  = 1'b1;
          end else begin
            // Column beyond the frame: consume the bin without writing.
            fd_nxt = bus.bin_last;
            if (bus.bin_last) col_nxt = '0;
          end
        end
      end
      DRAW: begin
        if (row == 6'(NUM_ROWS - 1)) begin
          state_nxt = IDLE;
          fd_nxt    = last_q;
          col_nxt   = last_q ? '0 : col + 1'b1;
        end else begin
          row_nxt  = row + 6'd1;
          ada_nxt  = ada + PIX_ADDR_W'(NUM_COLS);
          dina_nxt = pix_color(row + 6'd1, h, pk);
          wrea_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      row    <= '0;
      h      <= '0;
      pk     <= '0;
      col    <= '0;
      last_q <= 1'b0;
      ada    <= '0;
      dina   <= '0;
      wrea   <= 1'b0;
      fd     <= 1'b0;
    end else begin
      state  <= state_nxt;
      row    <= row_nxt;
      h      <= h_nxt;
      pk     <= pk_nxt;
      col    <= col_nxt;
      last_q <= last_nxt;
      ada    <= ada_nxt;
      dina   <= dina_nxt;
      wrea   <= wrea_nxt;
      fd     <= fd_nxt;
    end
  end

  // Held low during reset so the source never sees a handshake it cannot make.
  assign bus.bin_ready  = (state == IDLE) && !reset;
  assign bus.busy       = (state == DRAW);
  assign bus.pix_ada    = ada;
  assign bus.pix_dina   = dina;
  assign bus.pix_wrea   = wrea;
  assign bus.pix_cea    = wrea;
  assign bus.frame_done = fd;

endmodule

// File: tb/tb_spectrum_col_writer.sv
// tb/tb_spectrum_col_writer.sv - scoreboard bench for spectrum_col_writer
module tb_spectrum_col_writer;

  typedef struct {
    bit          fd;
    logic [12:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  int   mcol = 0;
  int   mpeak[96];
  int   fcnt = 0;
  bit   drawn;

  spectrum_col_writer_if bus();

  spectrum_col_writer dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_color(input int r, input int hh, input int p);
    if (p >= 1 && r == 64 - p) return 8'hFF;
    if (r >= 64 - hh) return (r < 16) ? 8'hE0 : 8'h1C;
    return 8'h00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per write or frame_done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("cea_eq_wrea", 32'(bus.pix_cea), 32'(bus.pix_wrea));
        if (bus.frame_done) begin
          checks++;
          if (exp_q.size() == 0 || !exp_q[0].fd) begin
            failures++;
            $display("FAIL frame_done unexpected at %0t actual=1 required=0", $time);
          end else void'(exp_q.pop_front());
        end
        if (bus.pix_wrea) begin
          checks++;
          if (exp_q.size() == 0 || exp_q[0].fd) begin
            failures++;
            $display("FAIL write unexpected addr=%0d data=%0h", bus.pix_ada, bus.pix_dina);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
          end else begin
            e = exp_q.pop_front();
            if (bus.pix_ada !== e.addr || bus.pix_dina !== e.data) begin
              failures++;
              $display("FAIL pixel actual addr=%0d data=%0h required addr=%0d data=%0h",
                       bus.pix_ada, bus.pix_dina, e.addr, e.data);
            end
          end
        end else begin
          check("idle_ada_zero", 32'(bus.pix_ada), 32'd0);
          check("idle_dina_zero", 32'(bus.pix_dina), 32'd0);
        end
      end
    end
  end

  task automatic start_bin(input logic [7:0] mag, input bit last, output bit dr);
    int h, p, w;
    h = int'(mag) / 4;
    p = 0;
    dr = (mcol < 96);
    if (dr) begin
`ifdef SPECTRUM_PEAK_HOLD_EN
      if (mpeak[mcol] < h) mpeak[mcol] = h;
      p = mpeak[mcol];
`endif
      for (int r = 0; r < 64; r++) exp_q.push_back('{1'b0, 13'(r * 96 + mcol), exp_color(r, h, p)});
      mcol++;
    end
    if (last) begin
      exp_q.push_back('{1'b1, 13'd0, 8'd0});
      mcol = 0;
`ifdef SPECTRUM_PEAK_HOLD_EN
      fcnt++;
      if (fcnt == 4) begin
        fcnt = 0;
        for (int i = 0; i < 96; i++) if (mpeak[i] > 0) mpeak[i]--;
      end
`endif
    end
    bus.bin_valid = 1'b1;
    bus.bin_mag   = mag;
    bus.bin_last  = last;
    w = 0;
    while (!bus.bin_ready) begin
      @(negedge clk);
      w++;
      if (w > 300) begin
        failures++;
        $display("FAIL ready_timeout actual=0 required=1");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bin_ready never rose");
      end
    end
    @(posedge clk);
    #1;
    bus.bin_valid = 1'b0;
    bus.bin_last  = 1'b0;
  endtask

  task automatic finish_bin(input bit dr);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("busy_after_accept", 32'(bus.busy), 32'(dr));
    end while (!bus.bin_ready && lat < 200);
    check("ready_latency", 32'(lat), dr ? 32'd65 : 32'd1);
  endtask

  task automatic send_bin(input logic [7:0] mag, input bit last);
    bit dr;
    start_bin(mag, last, dr);
    finish_bin(dr);
  endtask

  initial begin
    logic [7:0] mags[8];
    int w;
    mags = '{8'h00, 8'h04, 8'h3F, 8'h40, 8'hBF, 8'hC0, 8'hFC, 8'h7F};
    for (int i = 0; i < 96; i++) mpeak[i] = 0;
    bus.bin_valid = 1'b0;
    bus.bin_mag   = 8'h00;
    bus.bin_last  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.bin_ready), 32'd0);
    check("rst_wrea", 32'(bus.pix_wrea), 32'd0);
    check("rst_cea", 32'(bus.pix_cea), 32'd0);
    check("rst_ada", 32'(bus.pix_ada), 32'd0);
    check("rst_dina", 32'(bus.pix_dina), 32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_release", 32'(bus.bin_ready), 32'd1);

    // Half bar, full bar, assorted heights, short frame ending on bin 10
    send_bin(8'h80, 1'b0);
    send_bin(8'hFF, 1'b0);
    for (int i = 0; i < 7; i++) send_bin(mags[i], 1'b0);
    send_bin(mags[7], 1'b1);

    // Over-long frame: 100 bins, last four discarded
    for (int i = 0; i < 100; i++) send_bin(8'((i * 37 + 5) & 255), i == 99);
    send_bin(8'h40, 1'b0);

    // Reset during row 20 of column 1
    start_bin(8'hFC, 1'b0, drawn);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midreset_wrea", 32'(bus.pix_wrea), 32'd0);
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_ready", 32'(bus.bin_ready), 32'd0);
    exp_q.delete();
    mcol = 0;
    fcnt = 0;
    for (int i = 0; i < 96; i++) mpeak[i] = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_midreset", 32'(bus.bin_ready), 32'd1);

    // Column 0 after reset: all background, no marker
    send_bin(8'h00, 1'b1);
    // Peak hold on column 0: tall bar, then empty frames
    send_bin(8'hFC, 1'b1);
    for (int i = 0; i < 4; i++) send_bin(8'h00, 1'b1);

    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
